// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multi-cycle MIPS control FSM
package mc_ctrl_pkg;

    localparam logic [3:0] ST_FETCH  = 4'd0;
    localparam logic [3:0] ST_DECODE = 4'd1;
    localparam logic [3:0] ST_MEMADR = 4'd2;
    localparam logic [3:0] ST_MEMRD  = 4'd3;
    localparam logic [3:0] ST_MEMWB  = 4'd4;
    localparam logic [3:0] ST_MEMWR  = 4'd5;
    localparam logic [3:0] ST_REXEC  = 4'd6;
    localparam logic [3:0] ST_RWB    = 4'd7;
    localparam logic [3:0] ST_BRANCH = 4'd8;
    localparam logic [3:0] ST_JUMP   = 4'd9;
    localparam logic [3:0] ST_JAL    = 4'd10;
    localparam logic [3:0] ST_IEXEC  = 4'd11;
    localparam logic [3:0] ST_IWB    = 4'd12;
    localparam logic [3:0] ST_ERR    = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_BLT   = 6'd6;
    localparam logic [5:0] OP_BLE   = 6'd7;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LUI   = 6'd15;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [2:0] ALU_R   = 3'b000;
    localparam logic [2:0] ALU_BEQ = 3'b001;
    localparam logic [2:0] ALU_BNE = 3'b010;
    localparam logic [2:0] ALU_ADD = 3'b011;
    localparam logic [2:0] ALU_LUI = 3'b100;
    localparam logic [2:0] ALU_ORI = 3'b101;

    localparam logic [1:0] BT_BEQ = 2'b00;
    localparam logic [1:0] BT_BLE = 2'b01;
    localparam logic [1:0] BT_BLT = 2'b10;
    localparam logic [1:0] BT_BNE = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b11;

    localparam logic [1:0] RDST_RT = 2'b00;
    localparam logic [1:0] RDST_RD = 2'b01;
    localparam logic [1:0] RDST_RA = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // cls is the state DECODE dispatches to; ST_ERR for anything not legal
    typedef struct packed {
        logic [3:0] cls;
        logic [2:0] alu_op;
        logic [1:0] branch_type;
        logic       legal;
    } op_info_t;

endpackage

// File: rtl/mc_ctrl_op_rom.sv
// rtl/mc_ctrl_op_rom.sv - combinational opcode to class/alu_op/branch_type lookup
module mc_ctrl_op_rom
    import mc_ctrl_pkg::*;
#(
    parameter bit EN_BLT_BLE = 1'b1
) (
    input  logic [5:0] op_i,
    output op_info_t   info_o
);

    always_comb begin
        info_o = '{cls: ST_ERR, alu_op: ALU_ADD, branch_type: BT_BEQ, legal: 1'b0};
        case (op_i)
            OP_RTYPE: info_o = '{cls: ST_REXEC,  alu_op: ALU_R,   branch_type: BT_BEQ, legal: 1'b1};
            OP_J:     info_o = '{cls: ST_JUMP,   alu_op: ALU_ADD, branch_type: BT_BEQ, legal: 1'b1};
            OP_JAL:   info_o = '{cls: ST_JAL,    alu_op: ALU_ADD, branch_type: BT_BEQ, legal: 1'b1};
            OP_BEQ:   info_o = '{cls: ST_BRANCH, alu_op: ALU_BEQ, branch_type: BT_BEQ, legal: 1'b1};
            OP_BNE:   info_o = '{cls: ST_BRANCH, alu_op: ALU_BNE, branch_type: BT_BNE, legal: 1'b1};
            OP_BLT: if (EN_BLT_BLE)
                      info_o = '{cls: ST_BRANCH, alu_op: ALU_BEQ, branch_type: BT_BLT, legal: 1'b1};
            OP_BLE: if (EN_BLT_BLE)
                      info_o = '{cls: ST_BRANCH, alu_op: ALU_BEQ, branch_type: BT_BLE, legal: 1'b1};
            OP_ADDI:  info_o = '{cls: ST_IEXEC,  alu_op: ALU_ADD, branch_type: BT_BEQ, legal: 1'b1};
            OP_ORI:   info_o = '{cls: ST_IEXEC,  alu_op: ALU_ORI, branch_type: BT_BEQ, legal: 1'b1};
            OP_LUI:   info_o = '{cls: ST_IEXEC,  alu_op: ALU_LUI, branch_type: BT_BEQ, legal: 1'b1};
            OP_LW,
            OP_SW:    info_o = '{cls: ST_MEMADR, alu_op: ALU_ADD, branch_type: BT_BEQ, legal: 1'b1};
            default:  ;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multi-cycle MIPS control FSM with memory watchdog
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int ALU_OP_W    = 3,
    parameter int MEM_TIMEOUT = 16,
    parameter bit EN_BLT_BLE  = 1'b1,
    parameter int RET_W       = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [5:0]          instr_op_i,
    input  logic                mem_ready_i,
    input  logic                stall_i,
    output logic                pc_write_o,
    output logic                pc_write_cond_o,
    output logic [1:0]          pc_source_o,
    output logic                ir_write_o,
    output logic                i_or_d_o,
    output logic                mem_read_o,
    output logic                mem_write_o,
    output logic [1:0]          mem_to_reg_o,
    output logic [1:0]          reg_dst_o,
    output logic                reg_write_o,
    output logic                alu_src_a_o,
    output logic [1:0]          alu_src_b_o,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic [1:0]          branch_type_o,
    output logic [3:0]          state_o,
    output logic                illegal_o,
    output logic [RET_W-1:0]    retired_o
);

    localparam int WD_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    logic [3:0]       r_state;
    logic [WD_W-1:0]  r_wdog;
    logic [RET_W-1:0] r_retired;
    logic             r_illegal;

    logic [3:0] w_next;
    logic       w_complete;
    logic       w_mem_state;
    logic       w_timeout;
    logic       w_wr_en;
    logic [2:0] w_alu_op;
    op_info_t   w_info;

    mc_ctrl_op_rom #(.EN_BLT_BLE(EN_BLT_BLE)) u_op_rom (
        .op_i   (instr_op_i),
        .info_o (w_info)
    );

    assign w_mem_state = (r_state == ST_FETCH) || (r_state == ST_MEMRD) || (r_state == ST_MEMWR);
    assign w_timeout   = (MEM_TIMEOUT != 0) && w_mem_state && !mem_ready_i && (r_wdog == WD_LAST);
    assign w_wr_en     = !stall_i && !rst_i;

    always_comb begin
        w_next     = r_state;
        w_complete = 1'b0;
        case (r_state)
            ST_FETCH:  if (mem_ready_i) w_next = ST_DECODE;
            ST_DECODE: w_next = w_info.cls;
            ST_MEMADR: w_next = (instr_op_i == OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:  if (mem_ready_i) w_next = ST_MEMWB;
            ST_MEMWR:  if (mem_ready_i) begin
                           w_next     = ST_FETCH;
                           w_complete = 1'b1;
                       end
            ST_REXEC:  w_next = ST_RWB;
            ST_IEXEC:  w_next = ST_IWB;
            ST_MEMWB, ST_RWB, ST_IWB, ST_BRANCH, ST_JUMP, ST_JAL: begin
                w_next     = ST_FETCH;
                w_complete = 1'b1;
            end
            ST_ERR:    w_next = ST_ERR;
            default:   w_next = ST_ERR;
        endcase
        if (w_timeout) w_next = ST_ERR;
    end

    // Any state change restarts the watchdog, so every memory state starts its wait at zero
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_FETCH;
            r_wdog    <= '0;
            r_retired <= '0;
            r_illegal <= 1'b0;
        end else if (!stall_i) begin
            r_state <= w_next;
            if (w_next != r_state)
                r_wdog <= '0;
            else if (w_mem_state && !mem_ready_i)
                r_wdog <= r_wdog + 1'b1;
            if (w_complete)
                r_retired <= r_retired + 1'b1;
            if (w_next == ST_ERR)
                r_illegal <= 1'b1;
        end
    end

    always_comb begin
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        pc_source_o     = PCS_ALU;
        ir_write_o      = 1'b0;
        i_or_d_o        = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        mem_to_reg_o    = M2R_ALU;
        reg_dst_o       = RDST_RT;
        reg_write_o     = 1'b0;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = SRCB_RT;
        w_alu_op        = ALU_R;
        branch_type_o   = BT_BEQ;
        case (r_state)
            ST_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = SRCB_FOUR;
                w_alu_op    = ALU_ADD;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
            end
            ST_DECODE: begin
                alu_src_b_o = SRCB_IMM_SH;
                w_alu_op    = ALU_ADD;
            end
            ST_MEMADR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
                w_alu_op    = ALU_ADD;
            end
            ST_MEMRD: begin
                mem_read_o = 1'b1;
                i_or_d_o   = 1'b1;
            end
            ST_MEMWB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = M2R_MDR;
            end
            ST_MEMWR: begin
                mem_write_o = 1'b1;
                i_or_d_o    = 1'b1;
            end
            ST_REXEC: alu_src_a_o = 1'b1;
            ST_RWB: begin
                reg_write_o = 1'b1;
                reg_dst_o   = RDST_RD;
            end
            ST_IEXEC: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
                w_alu_op    = w_info.alu_op;
            end
            ST_IWB: reg_write_o = 1'b1;
            ST_BRANCH: begin
                alu_src_a_o     = 1'b1;
                pc_write_cond_o = 1'b1;
                pc_source_o     = PCS_ALUOUT;
                w_alu_op        = w_info.alu_op;
                branch_type_o   = w_info.branch_type;
            end
            ST_JUMP: begin
                pc_write_o  = 1'b1;
                pc_source_o = PCS_JUMP;
            end
            ST_JAL: begin
                pc_write_o   = 1'b1;
                pc_source_o  = PCS_JUMP;
                reg_write_o  = 1'b1;
                reg_dst_o    = RDST_RA;
                mem_to_reg_o = M2R_PC;
            end
            default: ;
        endcase
        // Stall and reset both veto every architectural write; mem_read stays as decoded
        pc_write_o      = pc_write_o && w_wr_en;
        pc_write_cond_o = pc_write_cond_o && w_wr_en;
        ir_write_o      = ir_write_o && w_wr_en;
        reg_write_o     = reg_write_o && w_wr_en;
        mem_write_o     = mem_write_o && w_wr_en;
    end

    assign alu_op_o  = ALU_OP_W'(w_alu_op);
    assign state_o   = r_state;
    assign illegal_o = r_illegal;
    assign retired_o = r_retired;

endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - scoreboard bench for mc_control_unit (default and reduced configs)
module tb_mc_control_unit;

    localparam int F_ST = 0, F_ILL = 4, F_BT = 5, F_ALU = 7, F_SRCB = 10, F_SRCA = 12;
    localparam int F_RW = 13, F_RDST = 14, F_M2R = 16, F_MW = 18, F_MR = 19, F_IORD = 20;
    localparam int F_IRW = 21, F_PCS = 22, F_PCWC = 24, F_PCW = 25;

    typedef struct {
        int          d;
        string       tag;
        logic [25:0] e;
        logic [25:0] m;
        bit          cr;
        logic [31:0] r;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v [2];
    logic        rdy_v [2];
    logic        stl_v [2];
    logic [5:0]  op_v  [2];
    logic [25:0] obs   [2];
    logic [31:0] ret_v [2];

    // dut 0: default parameters; dut 1: EN_BLT_BLE=0, MEM_TIMEOUT=4
    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic       pcw, pcwc, irw, iord, mr, mw, rw, srca, ill;
        logic [1:0] pcs, m2r, rdst, srcb, bt;
        logic [2:0] aluop;
        logic [3:0] st;
        mc_control_unit #(
            .ALU_OP_W    (3),
            .MEM_TIMEOUT ((g == 0) ? 16 : 4),
            .EN_BLT_BLE  (g == 0),
            .RET_W       (32)
        ) u_dut (
            .clk_i           (clk),
            .rst_i           (rst_v[g]),
            .instr_op_i      (op_v[g]),
            .mem_ready_i     (rdy_v[g]),
            .stall_i         (stl_v[g]),
            .pc_write_o      (pcw),
            .pc_write_cond_o (pcwc),
            .pc_source_o     (pcs),
            .ir_write_o      (irw),
            .i_or_d_o        (iord),
            .mem_read_o      (mr),
            .mem_write_o     (mw),
            .mem_to_reg_o    (m2r),
            .reg_dst_o       (rdst),
            .reg_write_o     (rw),
            .alu_src_a_o     (srca),
            .alu_src_b_o     (srcb),
            .alu_op_o        (aluop),
            .branch_type_o   (bt),
            .state_o         (st),
            .illegal_o       (ill),
            .retired_o       (ret_v[g])
        );
        assign obs[g] = {pcw, pcwc, pcs, irw, iord, mr, mw, m2r, rdst, rw, srca, srcb, aluop, bt, ill, st};
    end

    exp_t        q[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic [25:0] cur_e, cur_m;
    bit          cur_cr;
    logic [31:0] cur_r;

    task automatic fld(int lo, int w, int v);
        for (int i = 0; i < w; i++) begin
            cur_e[lo+i] = v[i];
            cur_m[lo+i] = 1'b1;
        end
    endtask

    // wr = {pc_write, pc_write_cond, ir_write, reg_write, mem_write}
    task automatic exp_begin(int s, logic [4:0] wr);
        cur_e  = '0;
        cur_m  = '0;
        cur_cr = 1'b0;
        cur_r  = '0;
        fld(F_ST, 4, s);
        fld(F_PCW, 1, int'(wr[4]));
        fld(F_PCWC, 1, int'(wr[3]));
        fld(F_IRW, 1, int'(wr[2]));
        fld(F_RW, 1, int'(wr[1]));
        fld(F_MW, 1, int'(wr[0]));
    endtask

    task automatic ret(int r);
        cur_cr = 1'b1;
        cur_r  = 32'(r);
    endtask

    task automatic push(int d, string tag);
        q.push_back('{d, tag, cur_e, cur_m, cur_cr, cur_r});
    endtask

    task automatic step(int d, bit r, bit rdy, bit stl, int o, int s, logic [4:0] wr);
        @(posedge clk);
        #1;
        rst_v[d] = r;
        rdy_v[d] = rdy;
        stl_v[d] = stl;
        op_v[d]  = 6'(o);
        exp_begin(s, wr);
    endtask

    task automatic fetch_decode(int o, int r);
        step(0, 0, 1, 0, o, 0, 5'b10100); ret(r); push(0, "fetch");
        step(0, 0, 1, 0, o, 1, 5'b00000); fld(F_SRCA, 1, 0); fld(F_SRCB, 2, 3); fld(F_ALU, 3, 3); push(0, "decode");
    endtask

    always @(negedge clk) begin : mon
        exp_t x;
        while (q.size() > 0) begin
            x = q.pop_front();
            n_chk++;
            if ((obs[x.d] & x.m) !== (x.e & x.m)) begin
                n_err++;
                $display("FAIL %s dut%0d: outputs=%h required=%h (mask %h)", x.tag, x.d, obs[x.d] & x.m, x.e & x.m, x.m);
            end
            if (x.cr) begin
                n_chk++;
                if (ret_v[x.d] !== x.r) begin
                    n_err++;
                    $display("FAIL %s dut%0d retired: got=%0d required=%0d", x.tag, x.d, ret_v[x.d], x.r);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_v[i] = 1'b1;
            rdy_v[i] = 1'b0;
            stl_v[i] = 1'b0;
            op_v[i]  = 6'd0;
        end

        // reset values, no writes while rst is high even with mem_ready
        step(0, 1, 1, 0, 0, 0, 5'b00000);
        fld(F_MR, 1, 1); fld(F_IORD, 1, 0); fld(F_SRCA, 1, 0); fld(F_SRCB, 2, 1); fld(F_ALU, 3, 3);
        fld(F_ILL, 1, 0); fld(F_PCS, 2, 0); fld(F_M2R, 2, 0); fld(F_RDST, 2, 0); fld(F_BT, 2, 0);
        ret(0); push(0, "reset");

        // R-type
        fetch_decode(0, 0);
        step(0, 0, 1, 0, 0, 6, 5'b00000); fld(F_SRCA, 1, 1); fld(F_SRCB, 2, 0); fld(F_ALU, 3, 0); push(0, "rexec");
        step(0, 0, 1, 0, 0, 7, 5'b00010); fld(F_RDST, 2, 1); fld(F_M2R, 2, 0); ret(0); push(0, "rwb");

        // LW with three unready cycles in MEMRD
        fetch_decode(35, 1);
        step(0, 0, 1, 0, 35, 2, 5'b00000); fld(F_SRCA, 1, 1); fld(F_SRCB, 2, 2); fld(F_ALU, 3, 3); push(0, "lw_memadr");
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 35, 3, 5'b00000); fld(F_MR, 1, 1); fld(F_IORD, 1, 1); push(0, "lw_memrd_wait");
        end
        step(0, 0, 1, 0, 35, 3, 5'b00000); fld(F_MR, 1, 1); fld(F_IORD, 1, 1); push(0, "lw_memrd_rdy");
        step(0, 0, 1, 0, 35, 4, 5'b00010); fld(F_M2R, 2, 1); fld(F_RDST, 2, 0); push(0, "lw_memwb");

        // SW
        fetch_decode(43, 2);
        step(0, 0, 1, 0, 43, 2, 5'b00000); push(0, "sw_memadr");
        step(0, 0, 1, 0, 43, 5, 5'b00001); fld(F_IORD, 1, 1); fld(F_MR, 1, 0); push(0, "sw_memwr");

        // BNE then BLT
        fetch_decode(5, 3);
        step(0, 0, 1, 0, 5, 8, 5'b01000);
        fld(F_ALU, 3, 2); fld(F_BT, 2, 3); fld(F_PCS, 2, 1); fld(F_SRCA, 1, 1); fld(F_SRCB, 2, 0); push(0, "bne_branch");
        fetch_decode(6, 4);
        step(0, 0, 1, 0, 6, 8, 5'b01000); fld(F_ALU, 3, 1); fld(F_BT, 2, 2); fld(F_PCS, 2, 1); push(0, "blt_branch");

        // JAL then J
        fetch_decode(3, 5);
        step(0, 0, 1, 0, 3, 10, 5'b10010); fld(F_PCS, 2, 2); fld(F_RDST, 2, 2); fld(F_M2R, 2, 3); push(0, "jal");
        fetch_decode(2, 6);
        step(0, 0, 1, 0, 2, 9, 5'b10000); fld(F_PCS, 2, 2); push(0, "jump");

        // stall two cycles in RWB
        fetch_decode(0, 7);
        step(0, 0, 1, 0, 0, 6, 5'b00000); push(0, "stall_rexec");
        step(0, 0, 1, 1, 0, 7, 5'b00000); ret(7); push(0, "stall_rwb_1");
        step(0, 0, 1, 1, 0, 7, 5'b00000); ret(7); push(0, "stall_rwb_2");
        step(0, 0, 1, 0, 0, 7, 5'b00010); fld(F_RDST, 2, 1); push(0, "stall_release");
        step(0, 0, 0, 0, 0, 0, 5'b00000); fld(F_MR, 1, 1); ret(8); push(0, "after_stall");

        // dut 1: BLE illegal when disabled
        step(1, 0, 1, 0, 7, 0, 5'b10100); ret(0); push(1, "b_fetch");
        step(1, 0, 1, 0, 7, 1, 5'b00000); push(1, "b_decode");
        step(1, 0, 1, 0, 7, 13, 5'b00000); fld(F_ILL, 1, 1); fld(F_MR, 1, 0); push(1, "b_illegal_op");
        step(1, 0, 1, 0, 7, 13, 5'b00000); fld(F_ILL, 1, 1); fld(F_MR, 1, 0); ret(0); push(1, "b_err_sticky");

        // ready on the last allowed cycle beats the timeout
        step(1, 1, 0, 0, 0, 13, 5'b00000);
        step(1, 0, 0, 0, 0, 0, 5'b00000); fld(F_ILL, 1, 0); ret(0); push(1, "b_reset_recover");
        step(1, 0, 0, 0, 0, 0, 5'b00000); push(1, "b_wait_1");
        step(1, 0, 0, 0, 0, 0, 5'b00000); push(1, "b_wait_2");
        step(1, 0, 1, 0, 0, 0, 5'b10100); push(1, "b_ready_last");
        step(1, 0, 0, 0, 0, 1, 5'b00000); fld(F_ILL, 1, 0); push(1, "b_ready_wins");

        // timeout in FETCH after four unready cycles
        step(1, 1, 0, 0, 0, 6, 5'b00000);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 0, 0, 0, 5'b00000); fld(F_ILL, 1, 0); ret(0); push(1, "b_to_wait");
        end
        step(1, 0, 0, 0, 0, 13, 5'b00000); fld(F_ILL, 1, 1); push(1, "b_timeout_err");
        step(1, 0, 1, 0, 0, 13, 5'b00000); fld(F_ILL, 1, 1); fld(F_MR, 1, 0); push(1, "b_timeout_sticky");
        step(1, 1, 0, 0, 0, 13, 5'b00000);
        step(1, 0, 0, 0, 0, 0, 5'b00000); fld(F_ILL, 1, 0); fld(F_MR, 1, 1); ret(0); push(1, "b_recover");

        @(posedge clk);
        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
